cordic_arbiter: RTL and testbench

//   Shares one cordic_pipe between NUM_REQ requesters. Round-robin grants angle

---
 rtl/cordic_arbiter.sv | 91 +++++++++
 tb/tb_cordic_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one cordic_pipe, tags in-flight requests and routes
// each result back to its issuing requester in issue order.
module cordic_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_WIDTH    = 24,
    parameter int MAX_INFLIGHT = 4,
    parameter int ISSUE_GAP    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*NUM_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_WIDTH-1:0]         rsp_x,
    output logic [NUM_WIDTH-1:0]         rsp_y,
    output logic                         cordic_data_loaded,
    output logic [NUM_WIDTH-1:0]         cordic_angle,
    input  logic [NUM_WIDTH-1:0]         cordic_x,
    input  logic [NUM_WIDTH-1:0]         cordic_y,
    input  logic                         cordic_data_computed,
    output logic                         busy,
    output logic                         spurious_err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(MAX_INFLIGHT);
    localparam int OW = TW + 1;
    localparam int GW = $clog2(ISSUE_GAP);

    logic [PW-1:0] rr_ptr, gnt_idx;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] tag_mem [MAX_INFLIGHT];
    logic [TW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          found, issue_ok, push, pop;
    logic [NUM_WIDTH-1:0] gnt_angle;

    assign pop      = cordic_data_computed && occ != '0;
    assign issue_ok = gap_cnt == '0 && (occ != OW'(MAX_INFLIGHT) || pop);
    assign busy     = occ != '0;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        req_ready = (found && issue_ok) ? NUM_REQ'(1) << gnt_idx : '0;
    end

    assign push      = |req_ready;
    assign gnt_angle = req_angle[int'(gnt_idx)*NUM_WIDTH +: NUM_WIDTH];

    // tag storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr             <= '0;
            gap_cnt            <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            occ                <= '0;
            cordic_data_loaded <= 1'b0;
            cordic_angle       <= '0;
            rsp_valid          <= '0;
            rsp_x              <= '0;
            rsp_y              <= '0;
            spurious_err       <= 1'b0;
        end else begin
            occ                <= occ + OW'(push) - OW'(pop);
            wr_ptr             <= wr_ptr + TW'(push);
            rd_ptr             <= rd_ptr + TW'(pop);
            gap_cnt            <= push ? GW'(ISSUE_GAP - 1) : gap_cnt - GW'(gap_cnt != '0);
            rr_ptr             <= push ? (gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + PW'(1)) : rr_ptr;
            cordic_data_loaded <= push;
            rsp_valid          <= pop ? NUM_REQ'(1) << tag_mem[rd_ptr] : '0;
            if (push) cordic_angle <= gnt_angle;
            if (pop) begin
                rsp_x <= cordic_x;
                rsp_y <= cordic_y;
            end
            if (cordic_data_computed && !pop) spurious_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: random and directed traffic against a queue-based arbiter model,
// with a behavioural cordic pipe of configurable latency answering each issue.
module tb_cordic_arbiter;
    localparam int N   = 4;
    localparam int W   = 24;
    localparam int MI  = 4;
    localparam int GAP = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_angle = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_x, rsp_y, cordic_angle;
    logic [W-1:0]   cordic_x = '0, cordic_y = '0;
    logic           cordic_data_loaded, cordic_data_computed = 1'b0, busy, spurious_err;

    cordic_arbiter #(.NUM_REQ(N), .NUM_WIDTH(W), .MAX_INFLIGHT(MI), .ISSUE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .cordic_data_loaded(cordic_data_loaded), .cordic_angle(cordic_angle),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_data_computed(cordic_data_computed),
        .busy(busy), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [W-1:0] a; } pipe_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, lat = 5, pct = 0;
    bit inj = 0;
    logic [N-1:0] req_mask = '0;
    bit pend [N];
    logic [W-1:0] ang [N];
    int m_rr = 0, m_gap = 0;
    int m_tags [$];
    logic [W-1:0] m_angle = '0, m_rx = '0, m_ry = '0;
    bit m_loaded = 0, m_err = 0;
    logic [N-1:0] m_rsp = '0;
    pipe_t pipe_q [$];
    int g_log [$];
    int g_cyc [$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fx(logic [W-1:0] a); return a ^ 24'h5A5A5A; endfunction
    function automatic logic [W-1:0] fy(logic [W-1:0] a); return a + 24'd1; endfunction

    task automatic step(bit do_rst);
        int g, t;
        bit dc, pop, ok;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] cx, cy;
        pipe_t p;
        for (int i = 0; i < N; i++) begin
            if (do_rst) pend[i] = 0;
            else if (!pend[i] && req_mask[i] && $urandom_range(0, 99) < pct) begin
                pend[i] = 1;
                ang[i]  = W'($urandom);
            end
            req_valid[i]         = pend[i];
            req_angle[i*W +: W]  = ang[i];
        end
        dc = 0;
        cx = W'($urandom);
        cy = W'($urandom);
        if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            dc = 1;
            cx = fx(pipe_q[0].a);
            cy = fy(pipe_q[0].a);
            void'(pipe_q.pop_front());
        end else if (inj) begin
            dc  = 1;
            inj = 0;
        end
        cordic_data_computed = dc;
        cordic_x = cx;
        cordic_y = cy;
        if (do_rst) rst = 1'b1;
        #1;
        pop = dc && m_tags.size() > 0;
        ok  = m_gap == 0 && (m_tags.size() < MI || pop);
        g   = -1;
        if (ok)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        exp_rdy = (g < 0) ? '0 : N'(1) << g;
        check("req_ready", req_ready, exp_rdy);
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
                g_log.push_back(i);
                g_cyc.push_back(cyc);
            end
        @(posedge clk);
        #1;
        if (do_rst) begin
            m_tags.delete();
            m_rr = 0; m_gap = 0; m_angle = '0; m_loaded = 0;
            m_rsp = '0; m_rx = '0; m_ry = '0; m_err = 0;
            rst = 1'b0;
        end else begin
            if (pop) begin
                t = m_tags.pop_front();
                m_rsp = N'(1) << t;
                m_rx = cx;
                m_ry = cy;
            end else m_rsp = '0;
            if (dc && !pop) m_err = 1;
            if (g >= 0) begin
                m_tags.push_back(g);
                m_rr = (g + 1) % N;
                m_gap = GAP - 1;
                m_angle = ang[g];
                m_loaded = 1;
                pend[g] = 0;
                p.due = cyc + 1 + lat;
                p.a = ang[g];
                pipe_q.push_back(p);
            end else begin
                m_loaded = 0;
                if (m_gap > 0) m_gap--;
            end
        end
        cyc++;
        check("data_loaded", cordic_data_loaded, m_loaded);
        check("cordic_angle", cordic_angle, m_angle);
        check("rsp_valid", rsp_valid, m_rsp);
        check("rsp_x", rsp_x, m_rx);
        check("rsp_y", rsp_y, m_ry);
        check("busy", busy, m_tags.size() != 0);
        check("spurious_err", spurious_err, m_err);
    endtask

    task automatic drain();
        pct = 0;
        for (int i = 0; i < 80 && (pipe_q.size() > 0 || m_tags.size() > 0 || pend.or() != 0); i++) step(0);
    endtask

    initial begin
        bit seen;
        int exp_seq [6] = '{1, 2, 3, 1, 2, 3};
        int exp_c [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin pend[i] = 0; ang[i] = '0; end
        step(1);
        check("rst_ready", req_ready, 0);

        // single request from requester 1
        pend[1] = 1; ang[1] = 24'h0C90FD; lat = 5;
        step(0);
        check("single_loaded", cordic_data_loaded, 1);
        check("single_angle", cordic_angle, 24'h0C90FD);
        step(0);
        check("single_loaded_fall", cordic_data_loaded, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0);
            if (rsp_valid == 4'b0010) seen = 1;
        end
        check("single_rsp", seen, 1);

        // all four continuously valid, long pipe fills the tag FIFO
        step(1);
        g_log.delete(); g_cyc.delete();
        lat = 22; req_mask = '1; pct = 100;
        for (int i = 0; i < 40; i++) step(0);
        drain();
        if (g_log.size() < 5) check("all_grants", g_log.size(), 5);
        else begin
            for (int i = 0; i < 5; i++) check("all_order", g_log[i], exp_c[i]);
            check("grant_gap", g_cyc[1] - g_cyc[0], GAP);
            check("fifth_grant", g_cyc[4] - g_cyc[0], 23);
        end

        // fairness among 1,2,3
        step(1);
        g_log.delete(); g_cyc.delete();
        lat = 3; req_mask = 4'b1110; pct = 100;
        for (int i = 0; i < 14; i++) step(0);
        drain();
        if (g_log.size() < 6) check("rr_grants", g_log.size(), 6);
        else for (int i = 0; i < 6; i++) check("rr_order", g_log[i], exp_seq[i]);

        // spurious result with nothing in flight
        step(1);
        req_mask = '0; inj = 1;
        for (int i = 0; i < 4; i++) step(0);
        check("spurious_sticky", spurious_err, 1);

        // reset with three in flight, stale results must not reach requesters
        step(1);
        lat = 22; req_mask = '1; pct = 100;
        for (int i = 0; i < 20 && m_tags.size() < 3; i++) step(0);
        check("inflight3", m_tags.size(), 3);
        step(1);
        check("rst_busy", busy, 0);
        check("rst_rsp", rsp_valid, 0);
        req_mask = '0; pct = 0;
        for (int i = 0; i < 30; i++) step(0);
        check("stale_err", spurious_err, 1);
        step(1);
        check("err_cleared", spurious_err, 0);
        lat = 4; pend[2] = 1; ang[2] = 24'h123456;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0);
            if (rsp_valid == 4'b0100 && rsp_x == fx(24'h123456)) seen = 1;
        end
        check("post_rst_rsp", seen, 1);

        // randomized traffic with varying pipe latency
        req_mask = '1;
        for (int r = 0; r < 6; r++) begin
            lat = (r % 3 == 0) ? 22 : (r % 3 == 1) ? 3 : 9;
            pct = 20 + 15 * (r % 3);
            for (int i = 0; i < 100; i++) step(0);
        end
        drain();
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
